// File: rtl/mac_pkg.sv
// Shared constants and helpers for the multi-lane MAC engine.
package mac_pkg;

    localparam int unsigned DEF_DATA_W  = 9;
    localparam int unsigned DEF_ACC_W   = 18;
    localparam int unsigned DEF_LANES   = 2;
    localparam int unsigned DEF_COUNT_W = 8;

    // Clamp value for the default accumulator width
    localparam logic [DEF_ACC_W-1:0] DEF_ACC_SAT = '1;

    function automatic int unsigned lane_off(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mac_accum_lanes_if.sv
// Operand/result bus of mac_accum_lanes; master drives operands, slave returns frame results.
interface mac_accum_lanes_if
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned LANES   = DEF_LANES,
    parameter int unsigned COUNT_W = DEF_COUNT_W
) ();

    logic                     in_valid;
    logic                     in_last;
    logic                     acc_clear;
    logic [LANES*DATA_W-1:0]  in_a;
    logic [LANES*DATA_W-1:0]  in_b;
    logic                     out_valid;
    logic [LANES*ACC_W-1:0]   out_acc;
    logic [COUNT_W-1:0]       out_count;
    logic [LANES-1:0]         out_ovf;

    modport master (
        output in_valid, in_last, acc_clear, in_a, in_b,
        input  out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_last, acc_clear, in_a, in_b,
        output out_valid, out_acc, out_count, out_ovf
    );

endinterface

// File: rtl/mac_lane.sv
// One MAC lane: registered product, accumulator with carry detect, sticky overflow flag.
// MAC_ACC_SATURATE_EN selects clamping instead of modulo wrap on carry-out.
module mac_lane
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              beat_i,
    input  logic              last_i,
    output logic [ACC_W-1:0]  acc_nxt_o,
    output logic              ovf_nxt_o
);

    logic [2*DATA_W-1:0] prod_d, prod_q;
    logic [ACC_W-1:0]    acc_d, acc_q;
    logic                ovf_d, ovf_q;
    logic [ACC_W:0]      sum;

    always_comb begin
        prod_d = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
        sum    = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
`ifdef MAC_ACC_SATURATE_EN
        acc_nxt_o = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_nxt_o = sum[ACC_W-1:0];
`endif
        ovf_nxt_o = ovf_q | sum[ACC_W];

        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (beat_i) begin
            // Final beat hands its sum to the top and restarts the lane
            acc_d = last_i ? '0 : acc_nxt_o;
            ovf_d = last_i ? 1'b0 : ovf_nxt_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prod_q <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: rtl/mac_accum_lanes.sv
// Multi-lane framed MAC top: shared valid/last pipeline, beat counter and result registers.
// Build option MAC_ACC_SATURATE_EN makes the lane accumulators clamp instead of wrap.
module mac_accum_lanes
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned LANES   = DEF_LANES,
    parameter int unsigned COUNT_W = DEF_COUNT_W
) (
    input logic             clock,
    input logic             resetn,
    mac_accum_lanes_if.slave bus
);

    logic                   v1_d, v1_q;
    logic                   l1_d, l1_q;
    logic [COUNT_W-1:0]     cnt_d, cnt_q, cnt_inc;
    logic                   out_valid_d, out_valid_q;
    logic [LANES*ACC_W-1:0] out_acc_d, out_acc_q;
    logic [COUNT_W-1:0]     out_count_d, out_count_q;
    logic [LANES-1:0]       out_ovf_d, out_ovf_q;
    logic [LANES*ACC_W-1:0] acc_nxt;
    logic [LANES-1:0]       ovf_nxt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk_i     (clock),
            .rst_ni    (resetn),
            .clear_i   (bus.acc_clear),
            .a_i       (bus.in_a[lane_off(i, DATA_W) +: DATA_W]),
            .b_i       (bus.in_b[lane_off(i, DATA_W) +: DATA_W]),
            .beat_i    (v1_q),
            .last_i    (l1_q),
            .acc_nxt_o (acc_nxt[lane_off(i, ACC_W) +: ACC_W]),
            .ovf_nxt_o (ovf_nxt[i])
        );
    end

    always_comb begin
        cnt_inc = (cnt_q == {COUNT_W{1'b1}}) ? cnt_q : cnt_q + COUNT_W'(1);

        // A beat presented alongside acc_clear still enters stage 1 as beat 0
        v1_d = bus.in_valid;
        l1_d = bus.in_valid & bus.in_last;

        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (bus.acc_clear) begin
            cnt_d = '0;
        end else if (v1_q) begin
            if (l1_q) begin
                out_valid_d = 1'b1;
                out_acc_d   = acc_nxt;
                out_count_d = cnt_inc;
                out_ovf_d   = ovf_nxt;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= '0;
        end else begin
            v1_q        <= v1_d;
            l1_q        <= l1_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accum_lanes.sv
// Scoreboard bench for mac_accum_lanes: directed frames queue expected results, a monitor checks pulses.
module tb_mac_accum_lanes;

    localparam int unsigned DATA_W  = 9;
    localparam int unsigned ACC_W   = 18;
    localparam int unsigned LANES   = 2;
    localparam int unsigned COUNT_W = 8;

    typedef struct packed {
        logic [ACC_W-1:0]   acc1;
        logic [ACC_W-1:0]   acc0;
        logic [COUNT_W-1:0] cnt;
        logic [LANES-1:0]   ovf;
    } exp_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    mac_accum_lanes_if #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .LANES   (LANES),
        .COUNT_W (COUNT_W)
    ) bus ();

    mac_accum_lanes #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .LANES   (LANES),
        .COUNT_W (COUNT_W)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic beat(input int a0, input int b0, input int a1, input int b1,
                        input bit last, input bit clr = 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_last   = last;
        bus.acc_clear = clr;
        bus.in_a      = {DATA_W'(a1), DATA_W'(a0)};
        bus.in_b      = {DATA_W'(b1), DATA_W'(b0)};
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.acc_clear = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_frame(input int acc0, input int acc1, input int cnt, input int ovf);
        exp_t e;
        e.acc0 = ACC_W'(acc0);
        e.acc1 = ACC_W'(acc1);
        e.cnt  = COUNT_W'(cnt);
        e.ovf  = LANES'(ovf);
        exp_q.push_back(e);
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_acc_lane0", 64'(bus.out_acc[0 +: ACC_W]), 64'(e.acc0));
                    check("out_acc_lane1", 64'(bus.out_acc[ACC_W +: ACC_W]), 64'(e.acc1));
                    check("out_count", 64'(bus.out_count), 64'(e.cnt));
                    check("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.acc_clear = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;

        // Reset with random inputs
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_last   = 1'($urandom);
            bus.acc_clear = 1'($urandom);
            bus.in_a      = (LANES*DATA_W)'($urandom);
            bus.in_b      = (LANES*DATA_W)'($urandom);
            @(negedge clock);
        end
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_acc", 64'(bus.out_acc), 64'd0);
        check("reset_out_count", 64'(bus.out_count), 64'd0);
        check("reset_out_ovf", 64'(bus.out_ovf), 64'd0);
        idle(1);
        resetn = 1'b1;
        idle(2);

        // Three-beat frame
        expect_frame(27, 243, 3, 0);
        beat(2, 3, 9, 9, 1'b0);
        beat(4, 5, 9, 9, 1'b0);
        beat(1, 1, 9, 9, 1'b1);
        idle(4);

        // Back-to-back frames, no bubble
        expect_frame(14, 1, 2, 0);
        expect_frame(9, 10, 1, 0);
        beat(1, 2, 0, 0, 1'b0);
        beat(3, 4, 1, 1, 1'b1);
        beat(3, 3, 2, 5, 1'b1);
        idle(4);

        // Lane 0 overflows, lane 1 does not
`ifdef MAC_ACC_SATURATE_EN
        expect_frame(262143, 2, 2, 1);
`else
        expect_frame(260098, 2, 2, 1);
`endif
        beat(511, 511, 1, 1, 1'b0);
        beat(511, 511, 1, 1, 1'b1);
        idle(4);

        // Gaps inside a frame
        expect_frame(13, 2, 2, 0);
        beat(2, 5, 1, 1, 1'b0);
        idle(3);
        beat(1, 3, 1, 1, 1'b1);
        idle(4);

        // Clear while last sits in stage 1; same-cycle beat starts a fresh frame
        expect_frame(7, 6, 1, 0);
        beat(2, 2, 3, 3, 1'b0);
        beat(3, 3, 3, 3, 1'b1);
        beat(1, 7, 2, 3, 1'b1, 1'b1);
        idle(4);

        // Beat counter saturates
        expect_frame(300, 0, 255, 0);
        for (int i = 0; i < 300; i++) beat(1, 1, 0, 0, i == 299);
        idle(4);

        // Reset mid-frame discards it and clears held results
        beat(4, 4, 1, 1, 1'b0);
        beat(6, 6, 1, 1, 1'b0);
        resetn = 1'b0;
        idle(1);
        check("midreset_out_acc", 64'(bus.out_acc), 64'd0);
        check("midreset_out_count", 64'(bus.out_count), 64'd0);
        resetn = 1'b1;
        expect_frame(25, 0, 1, 0);
        beat(5, 5, 0, 3, 1'b1);
        idle(4);
        check("held_out_count", 64'(bus.out_count), 64'd1);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            idle(1);
            wait_cnt++;
        end
        check("pending_expectations", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
